// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Holds the prefix byte values, the serial frame length and the
// assembler state encoding.
package ps2_pkg;

    // Prefix bytes that extend a scan-code sequence.
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    // Serial frame: start, 8 data bits (LSB first), odd parity, stop.
    localparam int PS2_FRAME_BITS = 11;

    // Maximum number of bytes held in the sequence accumulator.
    localparam int PS2_MAX_BYTES = 8;

    // Sequence assembler states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_PRTSCR = 2'd3
    } asm_state_t;

    // True for the bytes that never complete a sequence on their own.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_E0) || (b == PS2_F0);
    endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Output bundle of the PS/2 key receiver.
//
// Signalling: there is no back-pressure. key_strobe is a one-cycle pulse
// in the same cycle that ps2_key[64] inverts and ps2_key[63:0] takes the
// new sequence; ps2_key then holds until the next strobe. frame_err is an
// independent one-cycle pulse for each discarded serial frame and never
// coincides with a change of ps2_key. asm_state exposes the assembler
// state for observation only.
interface ps2_key_rx_if;
    import ps2_pkg::*;

    logic [64:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;
    asm_state_t  asm_state;

    modport master (
        output ps2_key,
        output key_strobe,
        output frame_err,
        output asm_state
    );

    modport slave (
        input ps2_key,
        input key_strobe,
        input frame_err,
        input asm_state
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver: synchronizes the raw lines, debounces the
// PS/2 clock, shifts in 11-bit frames on filtered falling edges and checks
// start, odd parity and stop. Emits one valid byte or one error pulse per
// frame, both registered.
// Optional build macro: PS2_FRAME_TIMEOUT_EN adds an abort of stalled
// partial frames after TIMEOUT_CYC cycles without a falling edge.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Reject nonsensical configurations at elaboration.
    if (FILTER_LEN < 1 || TIMEOUT_CYC < 1 || TOW > 31) begin : g_bad_param
        $error("ps2_frame_rx: FILTER_LEN and TIMEOUT_CYC must be >= 1");
    end

    logic [1:0]     r_clk_sync;
    logic [1:0]     r_data_sync;
    logic           r_filt_clk;
    logic [FCW-1:0] r_filt_cnt;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic           r_byte_valid;
    logic [7:0]     r_byte;
    logic           r_frame_err;

    logic w_clk_s;
    logic w_data_s;
    logic w_filt_done;
    logic w_fall;
    logic w_timeout;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    // The filter accepts a new level on the FILTER_LEN-th differing sample;
    // a falling edge is recognised in that very cycle so data is sampled
    // alongside it.
    assign w_filt_done = (r_filt_cnt == FCW'(FILTER_LEN - 1));
    assign w_fall      = r_filt_clk & ~w_clk_s & w_filt_done;

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    // Clock glitch filter: count consecutive samples differing from the
    // accepted level, any agreeing sample restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_done) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

`ifdef PS2_FRAME_TIMEOUT_EN
    logic [TOW-1:0] r_to_cnt;

    assign w_timeout = (r_bit_cnt != 4'd0) && (r_to_cnt == TOW'(TIMEOUT_CYC - 1));

    // Idle-time counter, running only while a frame is partially received.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Deserializer and frame check; outputs are single-cycle pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_timeout) begin
                // Silent abort: the partial frame is simply dropped.
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'h00;
                r_parity  <= 1'b0;
            end else if (w_fall) begin
                if (r_bit_cnt == 4'd0) begin
                    if (!w_data_s) begin
                        r_bit_cnt <= 4'd1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {w_data_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_parity  <= w_data_s;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else begin
                    // Stop bit: odd parity means the XOR over data+parity is 1.
                    if (w_data_s && (^{r_shift, r_parity})) begin
                        r_byte       <= r_shift;
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    r_bit_cnt <= 4'd0;
                    r_shift   <= 8'h00;
                    r_parity  <= 1'b0;
                end
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard key receiver: frame reception in ps2_frame_rx, scan-code
// sequence assembly here. Multi-byte sequences (E0/F0 prefixes, Print
// Screen, Pause) are collected into a 64-bit history and published as one
// update with a toggle bit and a strobe.
// Optional build macro: PS2_FRAME_TIMEOUT_EN (partial-frame timeout).
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_key_rx_if.master  key_if
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .i_clk        (clk_sys),
        .i_rst_n      (RESET_N),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    asm_state_t  r_state;
    logic [63:0] r_acc;
    logic [3:0]  r_cnt;
    logic [64:0] r_key;
    logic        r_strobe;

    logic [63:0] w_acc_n;
    logic [3:0]  w_cnt_n;
    logic        w_prtscr_hit;
    logic        w_complete;
    asm_state_t  w_next_state;

    assign w_acc_n      = {r_acc[55:0], w_byte};
    assign w_cnt_n      = r_cnt + 4'd1;
    // Exactly E0 12 (PrtScr make head) or E0 F0 7C (PrtScr break head).
    assign w_prtscr_hit = (w_acc_n == 64'h0000_0000_0000_E012) ||
                          (w_acc_n == 64'h0000_0000_00E0_F07C);

    // Decide, for the incoming byte, whether the sequence completes and
    // which state the assembler moves to otherwise.
    always_comb begin
        w_complete   = 1'b0;
        w_next_state = r_state;
        if (w_cnt_n == 4'(PS2_MAX_BYTES)) begin
            // A full accumulator always publishes; a 9th byte cannot pile up.
            w_complete = 1'b1;
        end else begin
            case (r_state)
                ST_PAUSE: w_next_state = ST_PAUSE;
                default: begin
                    if ((r_state == ST_IDLE) && (w_byte == PS2_E1)) begin
                        w_next_state = ST_PAUSE;
                    end else if (is_prefix(w_byte)) begin
                        w_next_state = (r_state == ST_PRTSCR) ? ST_PRTSCR : ST_PREFIX;
                    end else if ((r_state != ST_PRTSCR) && w_prtscr_hit) begin
                        w_next_state = ST_PRTSCR;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            endcase
        end
    end

    // Sequence assembler FSM with registered key output and strobe.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_acc    <= 64'h0;
            r_cnt    <= 4'd0;
            r_key    <= 65'h0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_byte_valid) begin
                if (w_complete) begin
                    r_key    <= {~r_key[64], w_acc_n};
                    r_strobe <= 1'b1;
                    r_acc    <= 64'h0;
                    r_cnt    <= 4'd0;
                    r_state  <= ST_IDLE;
                end else begin
                    r_acc    <= w_acc_n;
                    r_cnt    <= w_cnt_n;
                    r_state  <= w_next_state;
                end
            end
        end
    end

    assign key_if.ps2_key    = r_key;
    assign key_if.key_strobe = r_strobe;
    assign key_if.frame_err  = w_frame_err;
    assign key_if.asm_state  = r_state;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Testbench for ps2_key_rx: directed scan-code sequences driven as PS/2
// frames, expected key words queued at issue time and checked by a
// monitor whenever the receiver strobes or flags a frame error.
module tb_ps2_key_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF_BIT    = 15;

    // ---------------- clock / reset ----------------
    logic clk_sys  = 1'b0;
    logic RESET_N  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    int   cyc      = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    ps2_key_rx_if key_if ();

    ps2_key_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys  (clk_sys),
        .RESET_N  (RESET_N),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_if   (key_if)
    );

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];
    logic [0:0]  err_q[$];
    logic [64:0] model_key = '0;
    int          total = 0;
    int          bad   = 0;
    int          last_stop_cyc = 0;

    task automatic check65(input string name, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got=%0d expected range %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: pops an expectation for every strobe or frame error.
    always @(negedge clk_sys) begin
        if (RESET_N) begin
            if (key_if.key_strobe) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got key=%h expected no strobe", key_if.ps2_key);
                end else begin
                    model_key = exp_q.pop_front();
                    check65("ps2_key", key_if.ps2_key, model_key);
                    check_int("strobe_latency", cyc - last_stop_cyc,
                              FILTER_LEN + 2, FILTER_LEN + 5);
                end
            end
            if (key_if.frame_err) begin
                if (err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_err: got pulse expected none");
                end else begin
                    void'(err_q.pop_front());
                    check65("key_hold_on_err", key_if.ps2_key, model_key);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 first).
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b0;
            if (i == PS2_FRAME_BITS - 1) last_stop_cyc = cyc;
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip_par,
                                               input logic bad_stop);
        logic par;
        par = (~^b) ^ flip_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b0), PS2_FRAME_BITS);
        wait_cyc(40);
    endtask

    task automatic send_bad(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        err_q.push_back(1'b1);
        send_bits(make_frame(b, flip_par, bad_stop), PS2_FRAME_BITS);
        wait_cyc(40);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wait_cyc(5);
        check65("reset_key", key_if.ps2_key, 65'h0);
        check65("reset_strobe", {64'h0, key_if.key_strobe}, 65'h0);
        check65("reset_err", {64'h0, key_if.frame_err}, 65'h0);
        RESET_N = 1'b1;
        wait_cyc(10);

        // Single make code.
        exp_q.push_back({1'b1, 64'h1C});
        send_byte(8'h1C);

        // Extended break: E0 F0 75.
        exp_q.push_back({1'b0, 64'hE0F075});
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

        // Print Screen make.
        exp_q.push_back({1'b1, 64'hE012_E07C});
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);

        // Print Screen break.
        exp_q.push_back({1'b0, 64'hE0F0_7CE0_F012});
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);

        // Pause.
        exp_q.push_back({1'b1, 64'hE114_77E1_F014_F077});
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);

        // Bad parity, then a good frame decodes normally.
        send_bad(8'h1C, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 64'h1C});
        send_byte(8'h1C);

        // Bad stop bit.
        send_bad(8'h5A, 1'b0, 1'b1);
        check65("key_after_bad_stop", key_if.ps2_key, {1'b0, 64'h1C});

        // Eight prefix bytes: the 8th must complete.
        exp_q.push_back({1'b1, 64'hE0E0_E0E0_E0E0_E0E0});
        for (int i = 0; i < 8; i++) send_byte(8'hE0);

`ifdef PS2_FRAME_TIMEOUT_EN
        // Stalled partial frame is dropped silently, next frame decodes.
        send_bits(make_frame(8'h55, 1'b0, 1'b0), 5);
        wait_cyc(TIMEOUT_CYC + 60);
        exp_q.push_back({1'b0, 64'h29});
        send_byte(8'h29);
`endif

        // Reset in the middle of a frame.
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 4);
        RESET_N = 1'b0;
        #1;
        check65("midreset_key", key_if.ps2_key, 65'h0);
        check65("midreset_strobe", {64'h0, key_if.key_strobe}, 65'h0);
        check65("midreset_err", {64'h0, key_if.frame_err}, 65'h0);
        model_key = '0;
        wait_cyc(5);
        RESET_N = 1'b1;
        wait_cyc(20);
        exp_q.push_back({1'b1, 64'h1C});
        send_byte(8'h1C);

        wait_cyc(50);
        check_int("exp_q_drained", exp_q.size(), 0, 0);
        check_int("err_q_drained", err_q.size(), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
